hilo_div_unit: RTL
==================

// Module: hilo_div_unit
// PURPOSE
//  Multi-cycle iterative divider owning the HI/LO registers for div/divu, mthi/mtlo, mfhi/mflo.
//  Sits beside the execute stage. Its busy output is the producer side of the hazard unit's
//  divide-pending inputs: while busy is high, decode must stall any mfhi/mflo.
//  Restoring shift-subtract, one quotient bit per cycle; signed handled by magnitude + sign fixup.
// PARAMETERS
//  WIDTH   32   operand/result width; iteration count equals WIDTH
// PORTS
//  clock      in   1      single clock, all state updates on rising edge
//  reset      in   1      asynchronous, active-high; clears all state
//  start      in   1      one-cycle pulse: begin divide with dividend/divisor/is_signed
//  is_signed  in   1      1 = div (two's complement), 0 = divu
//  dividend   in   WIDTH  numerator (rs), sampled only when start accepted
//  divisor    in   WIDTH  denominator (rt), sampled only when start accepted
//  hi_we      in   1      mthi: HI <= wdata
//  lo_we      in   1      mtlo: LO <= wdata
//  wdata      in   WIDTH  move data for hi_we/lo_we
//  busy       out  1      divide in flight (state != IDLE); feeds hazard mf-op stall
//  done       out  1      one-cycle pulse, cycle after HI/LO receive a divide result
//  div_zero   out  1      sticky until next start: last completed divide had divisor 0
//  hi         out  WIDTH  HI register (remainder)
//  lo         out  WIDTH  LO register (quotient)
// BEHAVIOUR
//  Reset: state=IDLE; hi=0, lo=0, busy=0, done=0, div_zero=0; in-flight op discarded.
//  States: IDLE -> RUN (WIDTH cycles) -> FIX (1 cycle) -> IDLE.
//  IDLE: start=1 at edge N latches |dividend|, |divisor|, sign flags, zero flag; clears div_zero;
//    count=0; -> RUN. busy is high from cycle N+1.
//  RUN: each edge: rem = {rem,quo_msb}; if rem >= divisor then rem -= divisor, qbit=1; count++.
//    Remainder register is WIDTH+1 bits, no overflow. After WIDTH iterations -> FIX.
//  FIX (edge N+WIDTH+1): quotient negated if is_signed and signs differ; remainder negated if
//    is_signed and dividend negative; hi/lo written; done=1 next cycle; -> IDLE.
//    busy high exactly WIDTH+1 cycles (N+1..N+WIDTH+1); done high cycle N+WIDTH+2 only.
//  Divisor zero: full latency still taken; result forced LO=all ones, HI=raw dividend,
//    div_zero=1 with done.
//  Signed overflow (most-negative / -1): LO=most-negative, HI=0 (natural WIDTH-bit wrap).
//  Arithmetic mod 2^WIDTH; magnitude of most-negative is 2^(WIDTH-1) unsigned.
//  start while busy: restart with new operands (prior op discarded, no done for it).
//  hi_we/lo_we in IDLE: update selected register(s) next edge; other register unchanged.
//  hi_we/lo_we while busy (incl. FIX cycle): abort divide -> IDLE, apply move only, no done,
//    div_zero unchanged. Move has priority over start in the same cycle (start ignored).
//  hi/lo change only on FIX completion or a move; stable otherwise.
// TESTING
//  divu 100/7: start one cycle -> busy 33 cycles, then LO=14, HI=2, done one cycle, div_zero=0.
//  div -7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; div 7/-2 -> LO=0xFFFFFFFD, HI=1.
//  divu 5/0 -> after 33 busy cycles LO=0xFFFFFFFF, HI=5, div_zero=1; next start clears div_zero.
//  div 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0, div_zero=0.
//  Start 100/7, hi_we=1 wdata=0xABCD at busy cycle 10 -> busy=0 next cycle, HI=0xABCD,
//    LO unchanged, no done pulse.
//  Reset pulse mid-RUN, asynchronous to clock -> hi, lo, busy, done clear immediately;
//    after release, divu 9/3 -> LO=3, HI=0.

Source files
------------

// File: rtl/hilo_div_unit.sv
// HI/LO register owner with a multi-cycle restoring divider (div/divu) and mthi/mtlo moves.
// busy marks a divide in flight so the hazard unit can stall mfhi/mflo.
module hilo_div_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int unsigned REM_W = WIDTH + 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;

    logic [1:0]       state_q,    state_d;
    logic [CNT_W-1:0] count_q,    count_d;
    logic [REM_W-1:0] rem_q,      rem_d;
    logic [WIDTH-1:0] quo_q,      quo_d;
    logic [WIDTH-1:0] dvs_q,      dvs_d;
    logic [WIDTH-1:0] raw_q,      raw_d;
    logic             neg_quo_q,  neg_quo_d;
    logic             neg_rem_q,  neg_rem_d;
    logic             zero_q,     zero_d;
    logic [WIDTH-1:0] hi_q,       hi_d;
    logic [WIDTH-1:0] lo_q,       lo_d;
    logic             busy_q,     busy_d;
    logic             done_q,     done_d;
    logic             div_zero_q, div_zero_d;

    logic [REM_W-1:0] rem_shift;
    logic [REM_W-1:0] rem_sub;
    logic             qbit;
    logic [WIDTH-1:0] rem_mag;
    logic [WIDTH-1:0] abs_dividend;
    logic [WIDTH-1:0] abs_divisor;

    // Next-state, datapath and move/abort arbitration
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        rem_d      = rem_q;
        quo_d      = quo_q;
        dvs_d      = dvs_q;
        raw_d      = raw_q;
        neg_quo_d  = neg_quo_q;
        neg_rem_d  = neg_rem_q;
        zero_d     = zero_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        div_zero_d = div_zero_q;
        done_d     = 1'b0;

        rem_shift = REM_W'({rem_q, quo_q[WIDTH-1]});
        rem_sub   = rem_shift - {1'b0, dvs_q};
        qbit      = (rem_shift >= {1'b0, dvs_q});
        rem_mag   = WIDTH'(rem_q);

        abs_dividend = (is_signed && dividend[WIDTH-1]) ? (WIDTH'(0) - dividend) : dividend;
        abs_divisor  = (is_signed && divisor[WIDTH-1])  ? (WIDTH'(0) - divisor)  : divisor;

        if (hi_we || lo_we) begin
            // A move always wins: it aborts any divide and drops a same-cycle start
            if (hi_we) begin
                hi_d = wdata;
            end
            if (lo_we) begin
                lo_d = wdata;
            end
            state_d = S_IDLE;
        end else if (start) begin
            rem_d      = '0;
            quo_d      = abs_dividend;
            dvs_d      = abs_divisor;
            raw_d      = dividend;
            neg_quo_d  = is_signed && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
            neg_rem_d  = is_signed && dividend[WIDTH-1];
            zero_d     = (divisor == '0);
            div_zero_d = 1'b0;
            count_d    = '0;
            state_d    = S_RUN;
        end else begin
            case (state_q)
                S_RUN: begin
                    rem_d   = qbit ? rem_sub : rem_shift;
                    quo_d   = {quo_q[WIDTH-2:0], qbit};
                    count_d = count_q + CNT_W'(1);
                    if (count_q == CNT_W'(WIDTH - 1)) begin
                        state_d = S_FIX;
                    end
                end
                S_FIX: begin
                    if (zero_q) begin
                        lo_d = '1;
                        hi_d = raw_q;
                    end else begin
                        lo_d = neg_quo_q ? (WIDTH'(0) - quo_q) : quo_q;
                        hi_d = neg_rem_q ? (WIDTH'(0) - rem_mag) : rem_mag;
                    end
                    div_zero_d = zero_q;
                    done_d     = 1'b1;
                    state_d    = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            count_q    <= '0;
            rem_q      <= '0;
            quo_q      <= '0;
            dvs_q      <= '0;
            raw_q      <= '0;
            neg_quo_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            zero_q     <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            rem_q      <= rem_d;
            quo_q      <= quo_d;
            dvs_q      <= dvs_d;
            raw_q      <= raw_d;
            neg_quo_q  <= neg_quo_d;
            neg_rem_q  <= neg_rem_d;
            zero_q     <= zero_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            div_zero_q <= div_zero_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign div_zero = div_zero_q;
    assign hi       = hi_q;
    assign lo       = lo_q;

endmodule
